debayer_capture_controller: RTL and testbench

- Sequences the debayer pipeline one frame at a time. Sits between the camera sensor interface and the debayer.
- On a capture request it waits for the next clean frame start, passes exactly one frame (frame_valid, line_valid and pixel data) to the debayer, then blocks all further input.
- Measures the frame's width and height and flags any mismatch against the configured size. Firmware gets busy/done/error status without touching the datapath.

---
 rtl/debayer_capture_controller.sv | 197 +++++++++++++++++++
 tb/tb_debayer_capture_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debayer_capture_controller.sv
// ============================================================================
// debayer_capture_controller: passes exactly one sensor frame to the debayer
// per capture request and measures its size. Rev 1.0
// ============================================================================
`default_nettype none

module debayer_capture_controller #(
  parameter int PIXEL_WIDTH   = 10,
  parameter int COUNTER_WIDTH = 11
) (
  input  logic                     pixel_clock_in,
  input  logic                     reset_n_in,
  input  logic                     capture_start_in,
  input  logic                     abort_in,
  input  logic [COUNTER_WIDTH-1:0] expected_width_in,
  input  logic [COUNTER_WIDTH-1:0] expected_height_in,
  input  logic [PIXEL_WIDTH-1:0]   pixel_data_in,
  input  logic                     line_valid_in,
  input  logic                     frame_valid_in,
  output logic [PIXEL_WIDTH-1:0]   pixel_data_out,
  output logic                     line_valid_out,
  output logic                     frame_valid_out,
  output logic                     busy_out,
  output logic                     capture_done_out,
  output logic                     size_error_out,
  output logic [COUNTER_WIDTH-1:0] measured_width_out,
  output logic [COUNTER_WIDTH-1:0] measured_height_out
);

  localparam logic [COUNTER_WIDTH-1:0] C_CNT_MAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] C_CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic w_arm;
  logic w_capture;
  logic w_kill;
  logic w_finish;

  logic r_fv_d;
  logic r_lv_d;
  logic r_fv_out;
  logic r_lv_out;
  logic [PIXEL_WIDTH-1:0] r_pix_out;
  logic r_busy;
  logic r_done;
  logic r_err;

  logic [COUNTER_WIDTH-1:0] r_exp_w;
  logic [COUNTER_WIDTH-1:0] r_exp_h;
  logic [COUNTER_WIDTH-1:0] r_x_cnt;
  logic [COUNTER_WIDTH-1:0] r_line_cnt;
  logic [COUNTER_WIDTH-1:0] r_meas_w;

  logic                     w_lv_eff;
  logic                     w_fv_rise;
  logic                     w_fv_fall;
  logic                     w_line_end;
  logic [COUNTER_WIDTH-1:0] w_x_inc;
  logic [COUNTER_WIDTH-1:0] w_line_inc;
  logic [COUNTER_WIDTH-1:0] w_lines_now;
  logic                     w_width_bad;
  logic                     w_height_bad;

  // Line valid only counts inside the frame; stray pulses are dropped.
  assign w_lv_eff     = line_valid_in & frame_valid_in;
  assign w_fv_rise    = frame_valid_in & ~r_fv_d;
  assign w_fv_fall    = ~frame_valid_in & r_fv_d;
  assign w_line_end   = w_capture & r_lv_d & ~w_lv_eff;
  assign w_x_inc      = (r_x_cnt == C_CNT_MAX) ? r_x_cnt : r_x_cnt + C_CNT_ONE;
  assign w_line_inc   = (r_line_cnt == C_CNT_MAX) ? r_line_cnt : r_line_cnt + C_CNT_ONE;
  assign w_lines_now  = w_line_end ? w_line_inc : r_line_cnt;
  assign w_width_bad  = (r_x_cnt != r_exp_w) || (r_x_cnt == C_CNT_MAX);
  assign w_height_bad = (w_lines_now != r_exp_h) || (w_lines_now == C_CNT_MAX);

  always_ff @(posedge pixel_clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_arm        = 1'b0;
    w_capture    = 1'b0;
    w_kill       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (capture_start_in && !abort_in) begin
          w_next_state = ST_ARMED;
          w_arm        = 1'b1;
        end
      end
      ST_ARMED: begin
        if (abort_in) begin
          w_next_state = ST_IDLE;
        end else if (w_fv_rise) begin
          w_next_state = ST_ACTIVE;
          w_capture    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (abort_in) begin
          w_next_state = ST_IDLE;
          w_kill       = 1'b1;
        end else begin
          w_capture = 1'b1;
          if (w_fv_fall) begin
            w_next_state = ST_DONE;
            w_finish     = 1'b1;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pixel_clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_fv_d    <= 1'b0;
      r_lv_d    <= 1'b0;
      r_fv_out  <= 1'b0;
      r_lv_out  <= 1'b0;
      r_pix_out <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_fv_d    <= frame_valid_in;
      r_lv_d    <= w_capture & w_lv_eff;
      r_fv_out  <= w_capture & frame_valid_in;
      r_lv_out  <= w_capture & w_lv_eff;
      r_pix_out <= w_capture ? pixel_data_in : '0;
      r_busy    <= (w_next_state == ST_ARMED) || (w_next_state == ST_ACTIVE);
      r_done    <= w_finish;
    end
  end

  always_ff @(posedge pixel_clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_exp_w    <= '0;
      r_exp_h    <= '0;
      r_x_cnt    <= '0;
      r_line_cnt <= '0;
      r_meas_w   <= '0;
      r_err      <= 1'b0;
    end else if (w_arm) begin
      r_exp_w    <= expected_width_in;
      r_exp_h    <= expected_height_in;
      r_x_cnt    <= '0;
      r_line_cnt <= '0;
      r_meas_w   <= '0;
      r_err      <= 1'b0;
    end else if (w_kill) begin
      r_err <= 1'b1;
    end else if (w_capture) begin
      if (w_lv_eff) begin
        r_x_cnt <= w_x_inc;
      end else if (w_line_end) begin
        r_x_cnt <= '0;
      end
      if (w_line_end) begin
        r_line_cnt <= w_line_inc;
        if (r_line_cnt == '0) begin
          r_meas_w <= r_x_cnt;
        end
      end
      if ((w_line_end && w_width_bad) || (w_finish && w_height_bad)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign pixel_data_out      = r_pix_out;
  assign line_valid_out      = r_lv_out;
  assign frame_valid_out     = r_fv_out;
  assign busy_out            = r_busy;
  assign capture_done_out    = r_done;
  assign size_error_out      = r_err;
  assign measured_width_out  = r_meas_w;
  assign measured_height_out = r_line_cnt;

endmodule

`default_nettype wire

// File: tb/tb_debayer_capture_controller.sv
// ============================================================================
// tb_debayer_capture_controller: directed frames against a frame-level model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_debayer_capture_controller;

  localparam int PW = 10;
  localparam int CW = 11;
  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_PASS  = 2;
  localparam int M_DONE  = 3;

  logic          clk;
  logic          reset_n_in;
  logic          capture_start_in;
  logic          abort_in;
  logic [CW-1:0] expected_width_in;
  logic [CW-1:0] expected_height_in;
  logic [PW-1:0] pixel_data_in;
  logic          line_valid_in;
  logic          frame_valid_in;
  logic [PW-1:0] pixel_data_out;
  logic          line_valid_out;
  logic          frame_valid_out;
  logic          busy_out;
  logic          capture_done_out;
  logic          size_error_out;
  logic [CW-1:0] measured_width_out;
  logic [CW-1:0] measured_height_out;

  int checks;
  int errors;
  int n_done_seen;

  // model state
  int            m_mode;
  logic          m_prev_fv;
  int            m_w;
  int            m_h;
  int            m_run;
  int            m_lines[$];
  logic          n_fv, n_lv, n_busy, n_done, n_err;
  logic [PW-1:0] n_pix;
  int            n_mw, n_mh;
  logic          e_fv, e_lv, e_busy, e_done, e_err;
  logic [PW-1:0] e_pix;
  int            e_mw, e_mh;
  logic [PW-1:0] pcount;

  debayer_capture_controller #(.PIXEL_WIDTH(PW), .COUNTER_WIDTH(CW)) dut (
    .pixel_clock_in     (clk),
    .reset_n_in         (reset_n_in),
    .capture_start_in   (capture_start_in),
    .abort_in           (abort_in),
    .expected_width_in  (expected_width_in),
    .expected_height_in (expected_height_in),
    .pixel_data_in      (pixel_data_in),
    .line_valid_in      (line_valid_in),
    .frame_valid_in     (frame_valid_in),
    .pixel_data_out     (pixel_data_out),
    .line_valid_out     (line_valid_out),
    .frame_valid_out    (frame_valid_out),
    .busy_out           (busy_out),
    .capture_done_out   (capture_done_out),
    .size_error_out     (size_error_out),
    .measured_width_out (measured_width_out),
    .measured_height_out(measured_height_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_prev_fv = 1'b0; m_run = 0; m_w = 0; m_h = 0;
    m_lines.delete();
    n_fv = 0; n_lv = 0; n_busy = 0; n_done = 0; n_err = 0; n_pix = '0; n_mw = 0; n_mh = 0;
    e_fv = 0; e_lv = 0; e_busy = 0; e_done = 0; e_err = 0; e_pix = '0; e_mw = 0; e_mh = 0;
  endtask

  // Frame-level view: a capture passes every cycle from the frame's rising
  // edge to its falling edge; line lengths are collected and judged at the end.
  task automatic model_update();
    logic lvf, rise, fall, pass_now, bad;
    lvf      = line_valid_in & frame_valid_in;
    rise     = frame_valid_in & ~m_prev_fv;
    fall     = ~frame_valid_in & m_prev_fv;
    pass_now = 1'b0;
    n_done   = 1'b0;
    case (m_mode)
      M_IDLE: if (capture_start_in && !abort_in) begin
        m_mode = M_ARMED;
        m_w = int'(expected_width_in); m_h = int'(expected_height_in);
        n_err = 0; n_mw = 0; n_mh = 0; m_run = 0; m_lines.delete();
      end
      M_ARMED: if (abort_in) m_mode = M_IDLE;
               else if (rise) begin m_mode = M_PASS; pass_now = 1'b1; end
      M_PASS: if (abort_in) begin
        m_mode = M_IDLE; n_err = 1;
        n_mh = m_lines.size(); n_mw = (m_lines.size() > 0) ? m_lines[0] : 0;
      end else pass_now = 1'b1;
      default: m_mode = M_IDLE;
    endcase
    n_fv  = pass_now & frame_valid_in;
    n_lv  = pass_now & lvf;
    n_pix = pass_now ? pixel_data_in : '0;
    if (pass_now) begin
      if (lvf) m_run++;
      else if (m_run > 0) begin m_lines.push_back(m_run); m_run = 0; end
      if (fall) begin
        bad = (m_lines.size() != m_h);
        foreach (m_lines[i]) if (m_lines[i] != m_w) bad = 1'b1;
        n_err = bad; n_mh = m_lines.size();
        n_mw = (m_lines.size() > 0) ? m_lines[0] : 0;
        n_done = 1'b1; m_mode = M_DONE;
      end
    end
    n_busy = (m_mode == M_ARMED) || (m_mode == M_PASS);
    m_prev_fv = frame_valid_in;
  endtask

  task automatic step(input logic fv, input logic lv, input logic st, input logic ab);
    frame_valid_in = fv; line_valid_in = lv; capture_start_in = st; abort_in = ab;
    pixel_data_in = pcount; pcount = pcount + 10'd1;
    model_update();
    @(posedge clk);
    e_fv = n_fv; e_lv = n_lv; e_pix = n_pix; e_busy = n_busy; e_done = n_done;
    e_err = n_err; e_mw = n_mw; e_mh = n_mh;
    #1;
  endtask

  task automatic arm(input int w, input int h);
    expected_width_in = CW'(w); expected_height_in = CW'(h);
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic frame(input int w, input int h, input int bad_line, input int bad_len,
                       input int abort_line, input int start_line, input bit lv_at_fall);
    int len;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < h; l++) begin
      len = (l == bad_line) ? bad_len : w;
      for (int p = 0; p < len; p++)
        step(1'b1, 1'b1, (l == start_line) && (p == 0), (l == abort_line) && (p == 1));
      if (!(lv_at_fall && l == h - 1)) step(1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, lv_at_fall, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    check("frame_valid_out", frame_valid_out, e_fv);
    check("line_valid_out", line_valid_out, e_lv);
    check("pixel_data_out", pixel_data_out, e_pix);
    check("busy_out", busy_out, e_busy);
    check("capture_done_out", capture_done_out, e_done);
    if (!e_busy) begin
      check("size_error_out", size_error_out, e_err);
      check("measured_width_out", measured_width_out, e_mw);
      check("measured_height_out", measured_height_out, e_mh);
    end
    if (capture_done_out) n_done_seen++;
  end

  initial begin
    checks = 0; errors = 0; n_done_seen = 0; pcount = '0;
    reset_n_in = 1'b0; capture_start_in = 0; abort_in = 0;
    expected_width_in = '0; expected_height_in = '0;
    pixel_data_in = '0; line_valid_in = 0; frame_valid_in = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_fv", frame_valid_out, 0);
    check("reset_busy", busy_out, 0);
    check("reset_done", capture_done_out, 0);
    check("reset_mw", measured_width_out, 0);
    reset_n_in = 1'b1;
    step(0, 0, 0, 0);

    // 4x4 frame, start before the frame
    arm(4, 4);
    frame(4, 4, -1, 0, -1, -1, 0);
    check("f1_mw", measured_width_out, 4);
    check("f1_mh", measured_height_out, 4);
    check("f1_err", size_error_out, 0);
    check("f1_done", n_done_seen, 1);
    frame(4, 4, -1, 0, -1, -1, 0);
    check("f2_nocap_done", n_done_seen, 1);

    // start in the middle of a sensor frame: that frame blocked, next passed
    frame(4, 4, -1, 0, -1, 1, 0);
    check("mid_start_blocked", n_done_seen, 1);
    frame(4, 4, -1, 0, -1, -1, 0);
    check("mid_start_next", n_done_seen, 2);

    // size mismatches
    arm(8, 6);
    frame(8, 5, -1, 0, -1, -1, 0);
    check("short_err", size_error_out, 1);
    check("short_mw", measured_width_out, 8);
    check("short_mh", measured_height_out, 5);
    check("short_done", n_done_seen, 3);
    arm(8, 6);
    frame(8, 6, 2, 7, -1, -1, 0);
    check("narrow_err", size_error_out, 1);
    check("narrow_mw", measured_width_out, 8);
    check("narrow_mh", measured_height_out, 6);
    check("narrow_done", n_done_seen, 4);

    // abort during the third line
    arm(4, 4);
    frame(4, 4, -1, 0, 2, -1, 0);
    check("abort_busy", busy_out, 0);
    check("abort_err", size_error_out, 1);
    check("abort_mh", measured_height_out, 2);
    check("abort_mw", measured_width_out, 4);
    check("abort_no_done", n_done_seen, 4);

    // start and abort together in idle
    step(0, 0, 1, 1);
    check("start_abort_busy", busy_out, 0);
    frame(4, 4, -1, 0, -1, -1, 0);
    check("start_abort_nocap", n_done_seen, 4);

    // start while active is ignored; partial last line at frame end
    arm(4, 4);
    frame(4, 4, -1, 0, -1, 2, 1);
    check("active_start_done", n_done_seen, 5);
    check("active_start_err", size_error_out, 0);
    check("active_start_mh", measured_height_out, 4);
    frame(4, 4, -1, 0, -1, -1, 0);
    check("active_start_nocap", n_done_seen, 5);

    // asynchronous reset mid-line
    arm(4, 4);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("pre_reset_fv", frame_valid_out, 1);
    check("pre_reset_lv", line_valid_out, 1);
    reset_n_in = 1'b0;
    model_reset();
    #1;
    check("async_fv", frame_valid_out, 0);
    check("async_lv", line_valid_out, 0);
    check("async_busy", busy_out, 0);
    check("async_mw", measured_width_out, 0);
    @(posedge clk);
    @(posedge clk);
    #3 reset_n_in = 1'b1;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    arm(4, 4);
    frame(4, 4, -1, 0, -1, -1, 0);
    check("post_reset_mw", measured_width_out, 4);
    check("post_reset_mh", measured_height_out, 4);
    check("post_reset_err", size_error_out, 0);
    check("post_reset_done", n_done_seen, 6);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
